// File: rtl/fwd_hazard_unit_if.sv
// Bundle between the ID/EX pipeline registers and the forwarding/hazard unit.
// The master drives pipeline state; the slave (the unit) returns selects and stall info.
interface fwd_hazard_unit_if #(
    parameter int NUM_SRC    = 2,
    parameter int FWD_STAGES = 2,
    parameter int RA_W       = 5,
    parameter int CNT_W      = 16,
    parameter int SEL_W      = $clog2(FWD_STAGES + 1)
);
    logic [NUM_SRC*RA_W-1:0]    ex_rs;
    logic [FWD_STAGES*RA_W-1:0] stage_rd;
    logic [FWD_STAGES-1:0]      stage_regwrite;
    logic                       id_valid;
    logic [NUM_SRC*RA_W-1:0]    id_rs;
    logic                       id_mc_req;
    logic [RA_W-1:0]            ex_rd;
    logic                       ex_memread;
    logic                       ex_regwrite;
    logic                       mc_issue;
    logic [RA_W-1:0]            mc_rd;

    logic [NUM_SRC*SEL_W-1:0]   forward_sel;
    logic                       stall;
    logic                       mc_busy;
    logic                       mc_wb_valid;
    logic [RA_W-1:0]            mc_wb_rd;
    logic                       mc_overrun;
    logic [CNT_W-1:0]           stall_cnt;

    modport master (
        output ex_rs, stage_rd, stage_regwrite, id_valid, id_rs, id_mc_req,
               ex_rd, ex_memread, ex_regwrite, mc_issue, mc_rd,
        input  forward_sel, stall, mc_busy, mc_wb_valid, mc_wb_rd, mc_overrun, stall_cnt
    );

    modport slave (
        input  ex_rs, stage_rd, stage_regwrite, id_valid, id_rs, id_mc_req,
               ex_rd, ex_memread, ex_regwrite, mc_issue, mc_rd,
        output forward_sel, stall, mc_busy, mc_wb_valid, mc_wb_rd, mc_overrun, stall_cnt
    );
endinterface

// File: rtl/fwd_hazard_unit.sv
// Forwarding select, load-use / multi-cycle hazard stall, single-slot multi-cycle
// scoreboard and a saturating stall counter, sitting in front of the EX operand muxes.
module fwd_hazard_unit #(
    parameter int NUM_SRC    = 2,
    parameter int FWD_STAGES = 2,
    parameter int RA_W       = 5,
    parameter int MC_LAT     = 4,
    parameter int CNT_W      = 16,
    parameter int SEL_W      = $clog2(FWD_STAGES + 1)
) (
    input logic             clk,
    input logic             rst_n,
    fwd_hazard_unit_if.slave bus
);

    localparam int CNT_BITS = $clog2(MC_LAT);
    localparam logic [CNT_BITS-1:0] CNT_INIT = CNT_BITS'(MC_LAT - 1);
    localparam logic [CNT_BITS-1:0] CNT_ONE  = CNT_BITS'(1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t              state_q;
    logic [CNT_BITS-1:0] cnt_q;
    logic [RA_W-1:0]     mc_rd_q;
    logic                wb_valid_q;
    logic [RA_W-1:0]     wb_rd_q;
    logic                overrun_q;
    logic [CNT_W-1:0]    stall_cnt_q;
    logic [CNT_W-1:0]    stall_cnt_d;

    logic [NUM_SRC*SEL_W-1:0] fwd_sel;
    logic lu_hit;
    logic mraw_hit;
    logic lu;
    logic mraw;
    logic mstr;
    logic stall;

    // Stages are scanned farthest-first so the nearest qualifying stage overwrites the select.
    always_comb begin
        fwd_sel = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            for (int s = FWD_STAGES - 1; s >= 0; s--) begin
                if (bus.stage_regwrite[s] &&
                    (bus.stage_rd[s*RA_W +: RA_W] != '0) &&
                    (bus.stage_rd[s*RA_W +: RA_W] == bus.ex_rs[i*RA_W +: RA_W])) begin
                    fwd_sel[i*SEL_W +: SEL_W] = SEL_W'(s + 1);
                end
            end
        end
    end

    always_comb begin
        lu_hit   = 1'b0;
        mraw_hit = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (bus.id_rs[i*RA_W +: RA_W] == bus.ex_rd)  lu_hit   = 1'b1;
            if (bus.id_rs[i*RA_W +: RA_W] == mc_rd_q)    mraw_hit = 1'b1;
        end
    end

    // During the write-back pulse the register file write-through supplies the result.
    always_comb begin
        lu    = bus.id_valid & bus.ex_memread & bus.ex_regwrite & (bus.ex_rd != '0) & lu_hit;
        mraw  = bus.id_valid & (state_q == BUSY) & ~wb_valid_q & (mc_rd_q != '0) & mraw_hit;
        mstr  = bus.id_valid & bus.id_mc_req & (state_q == BUSY) & ~wb_valid_q;
        stall = lu | mraw | mstr;
    end

    // Issue loads MC_LAT-1; the write-back pulse is registered so it lands when cnt reaches 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            mc_rd_q    <= '0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            overrun_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    wb_valid_q <= 1'b0;
                    wb_rd_q    <= '0;
                    if (bus.mc_issue) begin
                        state_q <= BUSY;
                        cnt_q   <= CNT_INIT;
                        mc_rd_q <= bus.mc_rd;
                    end
                end
                BUSY: begin
                    if (bus.mc_issue) overrun_q <= 1'b1;
                    if (cnt_q == '0) begin
                        state_q    <= IDLE;
                        wb_valid_q <= 1'b0;
                        wb_rd_q    <= '0;
                    end else begin
                        cnt_q      <= cnt_q - CNT_ONE;
                        wb_valid_q <= (cnt_q == CNT_ONE);
                        wb_rd_q    <= (cnt_q == CNT_ONE) ? mc_rd_q : '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_cnt_q <= '0;
        else        stall_cnt_q <= stall_cnt_d;
    end

    assign bus.forward_sel = fwd_sel;
    assign bus.stall       = stall;
    assign bus.mc_busy     = (state_q == BUSY);
    assign bus.mc_wb_valid = wb_valid_q;
    assign bus.mc_wb_rd    = wb_rd_q;
    assign bus.mc_overrun  = overrun_q;
    assign bus.stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench: expectations are queued per cycle and write-back destinations per op;
// a negedge monitor pops and compares them against what the unit presents.
module tb_fwd_hazard_unit;

    localparam int RA_W = 5;
    localparam int SIG_FWD = 0, SIG_STALL = 1, SIG_BUSY = 2, SIG_OVR = 3,
                   SIG_CNT = 4, SIG_FWD3 = 5, SIG_WBV = 6, SIG_WBRD = 7;

    typedef struct {
        int          cyc;
        int          sig;
        logic [31:0] exp;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   cyc = 0;
    int   checkCnt = 0;
    int   passCnt = 0;
    exp_t expQ[$];
    logic [RA_W-1:0] wbQ[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fwd_hazard_unit_if #(.NUM_SRC(2), .FWD_STAGES(2), .RA_W(RA_W), .CNT_W(4))  busMain ();
    fwd_hazard_unit_if #(.NUM_SRC(3), .FWD_STAGES(3), .RA_W(RA_W), .CNT_W(16)) bus3 ();

    fwd_hazard_unit #(.NUM_SRC(2), .FWD_STAGES(2), .RA_W(RA_W), .MC_LAT(4), .CNT_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (busMain)
    );

    fwd_hazard_unit #(.NUM_SRC(3), .FWD_STAGES(3), .RA_W(RA_W), .MC_LAT(4), .CNT_W(16)) dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus3)
    );

    function automatic logic [31:0] getSig(int sig);
        case (sig)
            SIG_FWD:   return 32'(busMain.forward_sel);
            SIG_STALL: return 32'(busMain.stall);
            SIG_BUSY:  return 32'(busMain.mc_busy);
            SIG_OVR:   return 32'(busMain.mc_overrun);
            SIG_CNT:   return 32'(busMain.stall_cnt);
            SIG_FWD3:  return 32'(bus3.forward_sel);
            SIG_WBV:   return 32'(busMain.mc_wb_valid);
            SIG_WBRD:  return 32'(busMain.mc_wb_rd);
            default:   return 32'hdead_beef;
        endcase
    endfunction

    // Monitor: compare every expectation due this cycle and every write-back pulse.
    always @(negedge clk) begin : monitor
        int k;
        logic [31:0] got;
        k = 0;
        while (k < expQ.size()) begin
            if (expQ[k].cyc == cyc) begin
                got = getSig(expQ[k].sig);
                checkCnt++;
                if (got === expQ[k].exp) passCnt++;
                else $display("[TB] FAIL %s (cycle %0d): got %0h expected %0h",
                              expQ[k].name, cyc, got, expQ[k].exp);
                expQ.delete(k);
            end else begin
                k++;
            end
        end
        if (busMain.mc_wb_valid === 1'b1) begin
            checkCnt++;
            if (wbQ.size() == 0) begin
                $display("[TB] FAIL unexpectedWb (cycle %0d): got wb_valid=1 rd=%0d expected no write-back",
                         cyc, busMain.mc_wb_rd);
            end else begin
                logic [RA_W-1:0] expRd;
                expRd = wbQ.pop_front();
                if (busMain.mc_wb_rd === expRd) passCnt++;
                else $display("[TB] FAIL wbRd (cycle %0d): got %0d expected %0d",
                              cyc, busMain.mc_wb_rd, expRd);
            end
        end
    end

    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input int sig, input logic [31:0] exp, input string name);
        exp_t e;
        e.cyc  = cyc;
        e.sig  = sig;
        e.exp  = exp;
        e.name = name;
        expQ.push_back(e);
    endtask

    task automatic clearInputs();
        busMain.ex_rs = '0;  busMain.stage_rd = '0; busMain.stage_regwrite = '0;
        busMain.id_valid = 1'b0; busMain.id_rs = '0; busMain.id_mc_req = 1'b0;
        busMain.ex_rd = '0;  busMain.ex_memread = 1'b0; busMain.ex_regwrite = 1'b0;
        busMain.mc_issue = 1'b0; busMain.mc_rd = '0;
        bus3.ex_rs = '0;  bus3.stage_rd = '0; bus3.stage_regwrite = '0;
        bus3.id_valid = 1'b0; bus3.id_rs = '0; bus3.id_mc_req = 1'b0;
        bus3.ex_rd = '0;  bus3.ex_memread = 1'b0; bus3.ex_regwrite = 1'b0;
        bus3.mc_issue = 1'b0; bus3.mc_rd = '0;
    endtask

    initial begin
        clearInputs();
        #3 rst_n = 1'b0;

        applyStimulus();
        checkOutput(SIG_BUSY, 0, "rstBusy");
        checkOutput(SIG_OVR,  0, "rstOverrun");
        checkOutput(SIG_CNT,  0, "rstStallCnt");
        checkOutput(SIG_WBV,  0, "rstWbValid");
        checkOutput(SIG_WBRD, 0, "rstWbRd");
        applyStimulus();
        rst_n = 1'b1;

        // Forwarding on the 2-source, 2-stage instance
        applyStimulus();
        busMain.ex_rs = {5'd6, 5'd5}; busMain.stage_rd = {5'd5, 5'd5}; busMain.stage_regwrite = 2'b11;
        checkOutput(SIG_FWD, 32'b0001, "fwdMemWins");
        applyStimulus();
        busMain.stage_regwrite = 2'b10;
        checkOutput(SIG_FWD, 32'b0010, "fwdWbOnly");
        applyStimulus();
        busMain.ex_rs = {5'd5, 5'd5}; busMain.stage_regwrite = 2'b11;
        checkOutput(SIG_FWD, 32'b0101, "fwdBothMem");
        applyStimulus();
        busMain.ex_rs = {5'd6, 5'd5}; busMain.stage_rd = {5'd6, 5'd5};
        checkOutput(SIG_FWD, 32'b1001, "fwdSplit");
        applyStimulus();
        busMain.ex_rs = '0; busMain.stage_rd = '0;
        checkOutput(SIG_FWD, 32'b0000, "fwdZeroReg");

        // Forwarding on the 3-source, 3-stage instance
        bus3.stage_rd = {5'd12, 5'd3, 5'd4}; bus3.stage_regwrite = 3'b111;
        bus3.ex_rs = {5'd1, 5'd12, 5'd4};
        checkOutput(SIG_FWD3, 32'b00_11_01, "fwd3Stage2");
        applyStimulus();
        bus3.stage_regwrite = 3'b011;
        checkOutput(SIG_FWD3, 32'b00_00_01, "fwd3Stage2Off");

        // Load-use
        applyStimulus();
        clearInputs();
        busMain.id_valid = 1'b1; busMain.ex_memread = 1'b1; busMain.ex_regwrite = 1'b1;
        busMain.ex_rd = 5'd7; busMain.id_rs = {5'd7, 5'd3};
        checkOutput(SIG_STALL, 1, "luStall");
        applyStimulus();
        busMain.ex_rd = 5'd0; busMain.id_rs = {5'd0, 5'd3};
        checkOutput(SIG_STALL, 0, "luRdZero");
        applyStimulus();
        busMain.ex_rd = 5'd7; busMain.id_rs = {5'd7, 5'd3}; busMain.id_valid = 1'b0;
        checkOutput(SIG_STALL, 0, "luIdInvalid");
        applyStimulus();
        busMain.id_valid = 1'b1; busMain.ex_memread = 1'b0;
        checkOutput(SIG_STALL, 0, "luNotLoad");

        // Multi-cycle op, RAW stall until write-back
        applyStimulus();
        clearInputs();
        busMain.mc_issue = 1'b1; busMain.mc_rd = 5'd9; wbQ.push_back(5'd9);
        checkOutput(SIG_BUSY, 0, "mcIssueIdle");
        applyStimulus();
        busMain.mc_issue = 1'b0; busMain.id_valid = 1'b1; busMain.id_rs = {5'd0, 5'd9};
        checkOutput(SIG_BUSY, 1, "mcBusyT1"); checkOutput(SIG_STALL, 1, "mrawT1");
        checkOutput(SIG_WBV, 0, "mcNoWbT1");
        applyStimulus();
        checkOutput(SIG_STALL, 1, "mrawT2");
        applyStimulus();
        checkOutput(SIG_STALL, 1, "mrawT3"); checkOutput(SIG_WBV, 0, "mcNoWbT3");
        applyStimulus();
        checkOutput(SIG_STALL, 0, "mrawWbCycle"); checkOutput(SIG_BUSY, 1, "mcBusyT4");
        checkOutput(SIG_WBV, 1, "mcWbT4"); checkOutput(SIG_WBRD, 9, "mcWbRdT4");
        applyStimulus();
        checkOutput(SIG_BUSY, 0, "mcIdleT5"); checkOutput(SIG_WBV, 0, "mcWbLowT5");
        checkOutput(SIG_STALL, 0, "mcNoStallT5");

        // Overrun and structural stall
        applyStimulus();
        clearInputs();
        busMain.mc_issue = 1'b1; busMain.mc_rd = 5'd10; wbQ.push_back(5'd10);
        applyStimulus();
        busMain.mc_issue = 1'b0; busMain.id_valid = 1'b1; busMain.id_mc_req = 1'b1;
        checkOutput(SIG_STALL, 1, "mstrT1"); checkOutput(SIG_OVR, 0, "ovrClearT1");
        applyStimulus();
        busMain.mc_issue = 1'b1; busMain.mc_rd = 5'd11;
        checkOutput(SIG_STALL, 1, "mstrT2");
        applyStimulus();
        busMain.mc_issue = 1'b0;
        checkOutput(SIG_OVR, 1, "ovrSet"); checkOutput(SIG_BUSY, 1, "ovrBusyT3");
        applyStimulus();
        checkOutput(SIG_WBRD, 10, "ovrFirstOpWb"); checkOutput(SIG_STALL, 0, "mstrWbCycle");
        applyStimulus();
        checkOutput(SIG_BUSY, 0, "ovrIdleT5"); checkOutput(SIG_OVR, 1, "ovrSticky");
        checkOutput(SIG_STALL, 0, "mstrIdle");

        // Issue to r0 occupies the unit without a RAW stall
        applyStimulus();
        clearInputs();
        busMain.mc_issue = 1'b1; busMain.mc_rd = 5'd0; wbQ.push_back(5'd0);
        applyStimulus();
        busMain.mc_issue = 1'b0; busMain.id_valid = 1'b1; busMain.id_rs = '0;
        checkOutput(SIG_BUSY, 1, "rd0Busy"); checkOutput(SIG_STALL, 0, "rd0NoStall");
        repeat (4) applyStimulus();
        checkOutput(SIG_BUSY, 0, "rd0Done");

        // Stall counter saturation
        clearInputs();
        rst_n = 1'b0;
        checkOutput(SIG_CNT, 0, "rst2StallCnt"); checkOutput(SIG_OVR, 0, "rst2Overrun");
        applyStimulus();
        rst_n = 1'b1;
        busMain.id_valid = 1'b1; busMain.ex_memread = 1'b1; busMain.ex_regwrite = 1'b1;
        busMain.ex_rd = 5'd7; busMain.id_rs = {5'd0, 5'd7};
        checkOutput(SIG_STALL, 1, "cntStall"); checkOutput(SIG_CNT, 0, "cntStart");
        repeat (5) applyStimulus();
        checkOutput(SIG_CNT, 5, "cntFive");
        repeat (15) applyStimulus();
        checkOutput(SIG_CNT, 15, "cntSaturate");
        applyStimulus();
        clearInputs();
        checkOutput(SIG_CNT, 15, "cntHold"); checkOutput(SIG_STALL, 0, "cntNoStall");

        // Reset while busy abandons the op
        applyStimulus();
        busMain.mc_issue = 1'b1; busMain.mc_rd = 5'd13;
        applyStimulus();
        checkOutput(SIG_BUSY, 1, "abBusy");
        applyStimulus();
        busMain.mc_issue = 1'b0;
        checkOutput(SIG_OVR, 1, "abOverrun");
        applyStimulus();
        rst_n = 1'b0;
        checkOutput(SIG_BUSY, 0, "abRstBusy"); checkOutput(SIG_OVR, 0, "abRstOverrun");
        checkOutput(SIG_CNT, 0, "abRstCnt");   checkOutput(SIG_WBV, 0, "abRstWbv");
        applyStimulus();
        rst_n = 1'b1;
        repeat (6) applyStimulus();
        checkOutput(SIG_BUSY, 0, "abStayIdle");
        applyStimulus();
        applyStimulus();

        checkCnt++;
        if (wbQ.size() == 0 && expQ.size() == 0) passCnt++;
        else $display("[TB] FAIL drain: got %0d write-backs and %0d checks pending, expected 0 and 0",
                      wbQ.size(), expQ.size());

        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule
